router_param_core: RTL

//  Parametrised packet router: accepts header/payload/parity byte stream on one input port,

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_fifo.sv | 91 +++++++++
 rtl/router_param_core.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared state encoding and header field layout
// for the byte-stream packet router.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DISCARD,
    CHECK
  } state_t;

  localparam int DEST_LSB = 0;
  localparam int DEST_W   = 2;
  localparam int LEN_LSB  = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// router_fifo: one output channel queue with head read-out,
// full/valid flags and an unread-timeout flush.
module router_fifo
  import router_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          vld,
  output logic          flush,
  output logic          lost
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = cnt_w(DEPTH);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          do_push;
  logic          do_pop;
  logic          expire;

  assign vld  = (cnt != '0);
  assign full = (cnt == CW'(DEPTH));
  assign dout = vld ? mem[rd_ptr] : '0;

  // A pop in the same cycle keeps the queue alive, so it never expires then.
  assign expire = (TIMEOUT != 0)
               && vld
               && !pop
               && (timer == TW'(TMAX));

  assign do_push = push && !full && !expire;
  assign do_pop  = pop && vld;
  assign lost    = push && expire;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      timer  <= '0;
      flush  <= 1'b0;
    end else begin
      flush <= expire;
      if (expire) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        timer  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        unique case (1'b1)
          do_push && !do_pop: cnt <= cnt + CW'(1);
          do_pop && !do_push: cnt <= cnt - CW'(1);
          default: ;
        endcase
        if (!vld || pop) begin
          timer <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/router_param_core.sv
// router_param_core: header/payload/parity byte-stream router
// steering payload into NCH per-channel queues with backpressure.
module router_param_core
  import router_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int NCH     = 3,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DW-1:0]     datain,
  output logic              busy,
  input  logic [NCH-1:0]    read_enb,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    vldout,
  output logic              err,
  output logic              drop,
  output logic [NCH-1:0]    flush
);

  localparam int LW = DW - LEN_LSB;

  state_t            state;
  state_t            state_n;
  logic [DEST_W-1:0] dest;
  logic [DEST_W-1:0] dest_n;
  logic [LW-1:0]     len_cnt;
  logic [LW-1:0]     len_n;
  logic [DW-1:0]     par_acc;
  logic [DW-1:0]     par_n;
  logic [DW-1:0]     par_byte;
  logic [DW-1:0]     pbyte_n;
  logic              err_n;
  logic              drop_n;

  logic [NCH-1:0]    full;
  logic [NCH-1:0]    push;
  logic [NCH-1:0]    lost;
  logic [3:0]        full4;
  logic              dest_full;
  logic              load_push;
  logic              hdr_bad;
  logic [DEST_W-1:0] hdr_dest;
  logic [LW-1:0]     hdr_len;

  assign hdr_dest = datain[DEST_LSB +: DEST_W];
  assign hdr_len  = datain[LEN_LSB +: LW];
  assign hdr_bad  = ({1'b0, hdr_dest} >= 3'(NCH));

  // Pad to the full 2-bit destination space so dest never indexes out of range.
  always_comb begin
    full4 = '0;
    full4[NCH-1:0] = full;
  end

  assign dest_full = full4[dest];

  assign busy = ((state == LOAD) && dest_full)
             || (state == CHECK);

  assign load_push = (state == LOAD)
                  && pkt_valid
                  && !dest_full
                  && (len_cnt != '0);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign push[c] = load_push && (dest == DEST_W'(c));

    router_fifo #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push[c]),
      .pop    (read_enb[c]),
      .din    (datain),
      .dout   (data_out[c*DW +: DW]),
      .full   (full[c]),
      .vld    (vldout[c]),
      .flush  (flush[c]),
      .lost   (lost[c])
    );
  end

  always_comb begin
    state_n = state;
    dest_n  = dest;
    len_n   = len_cnt;
    par_n   = par_acc;
    pbyte_n = par_byte;
    err_n   = 1'b0;
    drop_n  = |lost;
    unique case (state)
      IDLE: begin
        if (pkt_valid) begin
          dest_n = hdr_dest;
          len_n  = hdr_len;
          par_n  = datain;
          if (hdr_bad) begin
            state_n = DISCARD;
            drop_n  = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        if (!pkt_valid) begin
          state_n = IDLE;
          drop_n  = 1'b1;
        end else if (!dest_full) begin
          if (len_cnt != '0) begin
            par_n = par_acc ^ datain;
            len_n = len_cnt - LW'(1);
          end else begin
            pbyte_n = datain;
            state_n = CHECK;
          end
        end
      end
      DISCARD: begin
        if (!pkt_valid || (len_cnt == '0)) begin
          state_n = IDLE;
        end else begin
          len_n = len_cnt - LW'(1);
        end
      end
      CHECK: begin
        err_n   = (par_acc != par_byte);
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      dest     <= '0;
      len_cnt  <= '0;
      par_acc  <= '0;
      par_byte <= '0;
      err      <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      dest     <= dest_n;
      len_cnt  <= len_n;
      par_acc  <= par_n;
      par_byte <= pbyte_n;
      err      <= err_n;
      drop     <= drop_n;
    end
  end

endmodule
